seg7_scan_driver: RTL and testbench

//  Display-side decoder for the traffic-light controller's countdown outputs.
//  - Inputs: two 8-bit BCD pairs, {tens,ones}; nibble 0xF means blank.
//  - Decodes the four digits to 7-segment codes and time-multiplexes them onto one

---
 rtl/seg7_pkg.sv | 35 +++
 rtl/bcd_seg7_decode.sv | 18 +
 rtl/seg7_scan_driver.sv | 118 +++++++++++
 tb/tb_seg7_scan_driver.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and glyph ROM for the 4-digit countdown display.
// Purely combinational helpers; no state, no backpressure.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [1:0] DIG_A1  = 2'd0;
    localparam logic [1:0] DIG_A10 = 2'd1;
    localparam logic [1:0] DIG_B1  = 2'd2;
    localparam logic [1:0] DIG_B10 = 2'd3;

    // Segment order {g,f,e,d,c,b,a}, active-low (common-anode panel).
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic logic is_bcd(input logic [3:0] nib);
        return nib <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_seg7_decode.sv
// Nibble to active-low 7-segment pattern, with forced blank.
// Latency 0 (combinational); no backpressure.
module bcd_seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       blank_en,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank_en) begin
            seg = bcd_to_seg(nib);
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Scans two BCD countdown pairs onto a shared 4-digit common-anode display, blinking in amber.
// Latency: outputs registered, one cycle behind the scan state; inputs sampled once per frame.
// No backpressure: free-running scan, inputs are snapshotted and never stalled.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV   = 1000,
    parameter int BLINK_FRMS = 64
) (
    input  logic       CLK,
    input  logic       R,
    input  logic [7:0] nIn1,
    input  logic [7:0] nIn2,
    input  logic       A_Light,
    input  logic       B_Light,
    output logic [6:0] Seg,
    output logic       DP,
    output logic [3:0] Dig
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int FRM_W = (BLINK_FRMS > 1) ? $clog2(BLINK_FRMS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRMS - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       dig_idx;
    logic [FRM_W-1:0] frame_cnt;
    logic             blink_off;
    logic [7:0]       sh_a;
    logic [7:0]       sh_b;
    logic [1:0]       sh_l;

    logic       slot_end;
    logic       frame_end;
    logic       frame_term;
    logic [1:0] lights_now;

    assign slot_end   = (div_cnt == DIV_LAST);
    assign frame_end  = slot_end && (dig_idx == DIG_B10);
    assign frame_term = frame_end && (frame_cnt == FRM_LAST);
    assign lights_now = {A_Light, B_Light};

    always_ff @(posedge CLK) begin
        if (R) begin
            div_cnt   <= '0;
            dig_idx   <= DIG_A1;
            frame_cnt <= '0;
            blink_off <= 1'b0;
            sh_a      <= 8'hFF;
            sh_b      <= 8'hFF;
            sh_l      <= 2'b00;
        end else begin
            div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
            if (slot_end) begin
                dig_idx <= dig_idx + 2'd1;
            end
            // Snapshot everything at the frame seam so a frame never mixes old and new counts.
            if (frame_end) begin
                sh_a      <= nIn1;
                sh_b      <= nIn2;
                sh_l      <= lights_now;
                frame_cnt <= frame_term ? '0 : frame_cnt + 1'b1;
                // Any green light ends amber immediately, not just at the blink boundary.
                if (lights_now != 2'b00) begin
                    blink_off <= 1'b0;
                end else if (frame_term) begin
                    blink_off <= ~blink_off;
                end
            end
        end
    end

    logic       street_b;
    logic       is_tens;
    logic       is_ones;
    logic [7:0] cur_word;
    logic [3:0] cur_nib;
    logic       cur_green;
    logic       zero_supp;
    logic       dig_off;
    logic [6:0] seg_nxt;
    logic       dp_nxt;
    logic [3:0] dig_nxt;

    // Blank codes switch the digit off; a suppressed leading zero keeps its enable but lights nothing.
    always_comb begin
        street_b  = (dig_idx == DIG_B1) || (dig_idx == DIG_B10);
        is_tens   = (dig_idx == DIG_A10) || (dig_idx == DIG_B10);
        is_ones   = (dig_idx == DIG_A1) || (dig_idx == DIG_B1);
        cur_word  = street_b ? sh_b : sh_a;
        cur_nib   = is_tens ? cur_word[7:4] : cur_word[3:0];
        cur_green = street_b ? sh_l[0] : sh_l[1];
        zero_supp = is_tens && (cur_nib == 4'd0) && is_bcd(cur_word[3:0]);
        dig_off   = blink_off || (div_cnt == '0) || !is_bcd(cur_nib);
        dig_nxt   = dig_off ? 4'hF : ~(4'b0001 << dig_idx);
        dp_nxt    = dig_off || !is_ones || !cur_green || (sh_l == 2'b11);
    end

    bcd_seg7_decode u_decode (
        .nib      (cur_nib),
        .blank_en (dig_off || zero_supp),
        .seg      (seg_nxt)
    );

    always_ff @(posedge CLK) begin
        if (R) begin
            Seg <= SEG_BLANK;
            DP  <= 1'b1;
            Dig <= 4'hF;
        end else begin
            Seg <= seg_nxt;
            DP  <= dp_nxt;
            Dig <= dig_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: frame-position reference model plus directed display scenarios.
module tb_seg7_scan_driver;

    localparam int SD    = 4;
    localparam int BF    = 2;
    localparam int FRAME = 4 * SD;

    logic       CLK = 1'b0;
    logic       R = 1'b1;
    logic [7:0] nIn1 = 8'hFF;
    logic [7:0] nIn2 = 8'hFF;
    logic       A_Light = 1'b0;
    logic       B_Light = 1'b0;
    logic [6:0] Seg;
    logic       DP;
    logic [3:0] Dig;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    seg7_scan_driver #(.SCAN_DIV(SD), .BLINK_FRMS(BF)) dut (
        .CLK     (CLK),
        .R       (R),
        .nIn1    (nIn1),
        .nIn2    (nIn2),
        .A_Light (A_Light),
        .B_Light (B_Light),
        .Seg     (Seg),
        .DP      (DP),
        .Dig     (Dig)
    );

    logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Reference state: cycles since reset plus what the last frame seam captured.
    int         m_n = 0;
    int         m_frm = 0;
    logic [7:0] m_a = 8'hFF;
    logic [7:0] m_b = 8'hFF;
    logic [1:0] m_l = 2'b00;
    bit         m_blank = 1'b0;
    bit         m_valid = 1'b0;
    logic [6:0] e_seg = 7'h7F;
    logic       e_dp = 1'b1;
    logic [3:0] e_dig = 4'hF;

    logic [6:0] seen_seg [16];
    logic       seen_dp [16];
    int         seen_hit [16];
    int         low_cycles = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int pos;
        int idx;
        logic [7:0] word;
        logic [3:0] nib;
        bit tens;
        bit st_b;
        bit green;
        if (R) begin
            e_seg = 7'h7F; e_dp = 1'b1; e_dig = 4'hF;
            m_n = 0; m_frm = 0; m_a = 8'hFF; m_b = 8'hFF; m_l = 2'b00;
            m_blank = 1'b0; m_valid = 1'b1;
            return;
        end
        if (!m_valid) return;
        pos   = m_n % FRAME;
        idx   = pos / SD;
        st_b  = (idx >= 2);
        tens  = ((idx % 2) == 1);
        word  = st_b ? m_b : m_a;
        nib   = tens ? word[7:4] : word[3:0];
        green = st_b ? m_l[0] : m_l[1];
        e_seg = 7'h7F; e_dp = 1'b1; e_dig = 4'hF;
        if ((pos % SD) != 0 && !m_blank && nib <= 4'd9) begin
            e_dig = ~(4'b0001 << idx);
            if (tens && nib == 4'd0 && word[3:0] <= 4'd9) e_seg = 7'h7F;
            else e_seg = glyph[nib];
            e_dp = !(!tens && green && m_l != 2'b11);
        end
        if (pos == FRAME - 1) begin
            m_a = nIn1; m_b = nIn2; m_l = {A_Light, B_Light};
            m_frm++;
            if (m_l != 2'b00) m_blank = 1'b0;
            else if (m_frm == BF) m_blank = !m_blank;
            if (m_frm == BF) m_frm = 0;
        end
        m_n++;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        if (m_valid) begin
            chk("seg", {1'b0, Seg}, {1'b0, e_seg});
            chk("dp",  {7'h0, DP},  {7'h0, e_dp});
            chk("dig", {4'h0, Dig}, {4'h0, e_dig});
            if (Dig != 4'hF) begin
                seen_seg[Dig] = Seg;
                seen_dp[Dig]  = DP;
                seen_hit[Dig]++;
                low_cycles++;
            end
        end
    endtask

    task automatic clear_seen();
        for (int i = 0; i < 16; i++) begin
            seen_seg[i] = 7'h7F; seen_dp[i] = 1'b1; seen_hit[i] = 0;
        end
        low_cycles = 0;
    endtask

    task automatic run_to(input int pos);
        for (int i = 0; i < FRAME && (m_n % FRAME) != pos; i++) tick();
    endtask

    task automatic count_visible(input int frames, output int vis);
        vis = 0;
        for (int f = 0; f < frames; f++) begin
            low_cycles = 0;
            repeat (FRAME) tick();
            if (low_cycles > 0) vis++;
        end
    endtask

    initial begin
        int vis;
        int r;
        clear_seen();

        // Reset, then the first frame must stay dark while the new counts are captured.
        R = 1'b1;
        repeat (3) tick();
        R = 1'b0;
        nIn1 = 8'h25; nIn2 = 8'h07; A_Light = 1'b1; B_Light = 1'b0;
        clear_seen();
        repeat (FRAME) tick();
        chk("rst_frame_dark", 8'(low_cycles), 8'd0);

        clear_seen();
        repeat (FRAME) tick();
        chk("a1_seg",  {1'b0, seen_seg[4'hE]}, 8'h12);
        chk("a1_dp",   {7'h0, seen_dp[4'hE]},  8'h00);
        chk("a1_len",  8'(seen_hit[4'hE]),     8'(SD - 1));
        chk("a10_seg", {1'b0, seen_seg[4'hD]}, 8'h24);
        chk("b1_seg",  {1'b0, seen_seg[4'hB]}, 8'h78);
        chk("b1_dp",   {7'h0, seen_dp[4'hB]},  8'h01);
        chk("b10_on",  8'(seen_hit[4'h7] != 0), 8'd1);
        chk("b10_seg", {1'b0, seen_seg[4'h7]}, 8'h7F);

        // Blank A pair and "00" on B; visible one frame after the seam that captures it.
        nIn1 = 8'hFF; nIn2 = 8'h00;
        repeat (FRAME) tick();
        clear_seen();
        repeat (FRAME) tick();
        chk("blankA_a1",  8'(seen_hit[4'hE]), 8'd0);
        chk("blankA_a10", 8'(seen_hit[4'hD]), 8'd0);
        chk("zero_b1",    {1'b0, seen_seg[4'hB]}, 8'h40);
        chk("zero_b10",   {1'b0, seen_seg[4'h7]}, 8'h7F);

        // Amber: both greens off gives a 2-on / 2-off frame pattern after settling.
        nIn1 = 8'h25; nIn2 = 8'h07; A_Light = 1'b0; B_Light = 1'b0;
        repeat (2 * FRAME) tick();
        count_visible(8, vis);
        chk("blink_vis", 8'(vis), 8'd4);
        A_Light = 1'b1;
        repeat (FRAME) tick();
        count_visible(3, vis);
        chk("blink_stop", 8'(vis), 8'd3);

        // Mid-frame input change is held off until the next seam.
        run_to(SD);
        nIn1 = 8'h39;
        clear_seen();
        run_to(0);
        chk("mid_a10_old", {1'b0, seen_seg[4'hD]}, 8'h24);
        clear_seen();
        repeat (FRAME) tick();
        chk("mid_a1_new",  {1'b0, seen_seg[4'hE]}, 8'h10);
        chk("mid_a10_new", {1'b0, seen_seg[4'hD]}, 8'h30);

        // Reset in the middle of a B-ones slot.
        run_to(2 * SD + 2);
        R = 1'b1;
        tick();
        chk("midrst_seg", {1'b0, Seg}, 8'h7F);
        chk("midrst_dp",  {7'h0, DP},  8'h01);
        chk("midrst_dig", {4'h0, Dig}, 8'h0F);
        R = 1'b0;
        clear_seen();
        repeat (FRAME) tick();
        chk("midrst_dark", 8'(low_cycles), 8'd0);
        clear_seen();
        repeat (FRAME) tick();
        chk("midrst_vis", {1'b0, seen_seg[4'hE]}, 8'h10);

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                r = $urandom_range(0, 11); nIn1[3:0] = (r > 9) ? 4'hF : 4'(r);
                r = $urandom_range(0, 11); nIn1[7:4] = (r > 9) ? 4'hF : 4'(r);
                r = $urandom_range(0, 11); nIn2[3:0] = (r > 9) ? 4'hF : 4'(r);
                r = $urandom_range(0, 11); nIn2[7:4] = (r > 9) ? 4'hF : 4'(r);
            end
            if ($urandom_range(0, 199) == 0) begin
                A_Light = 1'($urandom_range(0, 1));
                B_Light = 1'($urandom_range(0, 1));
            end
            R = ($urandom_range(0, 699) == 0);
            tick();
        end
        R = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
